// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain.
// The handshake beat struct is declared by each user module as a typedef,
// because its data width is a parameter of that module.
package pipe_pkg;

  // Largest supported chain depth.
  localparam int MAX_DEPTH = 16;

  // Occupancy counter width: must represent 0..DEPTH+1 (one optional skid entry).
  function automatic int clog2_plus2(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// The stage advances when it is empty or when the stage downstream advances.
// The data register only loads when a valid beat arrives, so an emptied
// stage keeps its old data instead of toggling.
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign ready = !valid || down_ready;

  // Load the upstream beat when this stage can advance; reset/flush squash it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: DEPTH handshaked stages with flush and a
// registered occupancy count.
// Optional build macro PIPE_REG_CHAIN_SKID_EN adds a one-entry skid buffer in
// front of stage 0 so that in_ready comes straight from a flop and the
// combinational ready path to upstream is broken (capacity becomes DEPTH+1).
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               COUNT_W     = clog2_plus2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } beat_t;

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be within 1..16");
  end

  beat_t            head_s;        // beat offered to stage 0
  logic             head_ready_s;  // stage 0 can load this cycle
  logic [DEPTH-1:0] st_valid_s;
  logic [WIDTH-1:0] st_data_s [DEPTH];
  logic             in_fire_s;
  logic             out_fire_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid_s;
    logic [WIDTH-1:0] up_data_s;
    logic             down_ready_s;
    logic             ready_s;

    if (i == 0) begin : g_first
      assign up_valid_s = head_s.valid;
      assign up_data_s  = head_s.data;
    end else begin : g_next
      assign up_valid_s = st_valid_s[i-1];
      assign up_data_s  = st_data_s[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign down_ready_s = out_ready;
    end else begin : g_inner
      assign down_ready_s = g_stage[i+1].ready_s;
    end

    pipe_reg_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_valid_s),
      .up_data    (up_data_s),
      .down_ready (down_ready_s),
      .ready      (ready_s),
      .valid      (st_valid_s[i]),
      .data       (st_data_s[i])
    );
  end

  assign head_ready_s = g_stage[0].ready_s;
  assign out_valid    = st_valid_s[DEPTH-1];
  assign out_data     = st_data_s[DEPTH-1];

`ifdef PIPE_REG_CHAIN_SKID_EN
  beat_t skid_r;

  assign in_ready = !skid_r.valid;

  // A parked skid beat goes to stage 0 ahead of any new upstream data.
  always_comb begin
    head_s = '0;
    if (skid_r.valid) begin
      head_s = skid_r;
    end else begin
      head_s.valid = in_valid;
      head_s.data  = in_data;
    end
  end

  // Park a beat accepted while stage 0 is blocked; release it once stage 0 loads.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_r.valid <= 1'b0;
      skid_r.data  <= RESET_VALUE;
    end else if (skid_r.valid) begin
      if (head_ready_s) begin
        skid_r.valid <= 1'b0;
      end
    end else if (in_valid && !head_ready_s) begin
      skid_r.valid <= 1'b1;
      skid_r.data  <= in_data;
    end
  end
`else
  assign head_s.valid = in_valid;
  assign head_s.data  = in_data;
  assign in_ready     = head_ready_s;
`endif

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;

  // Occupancy: +1 per accepted beat, -1 per delivered beat, cleared by reset/flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (in_fire_s && !out_fire_s) begin
      count <= count + COUNT_W'(1);
    end else if (!in_fire_s && out_fire_s) begin
      count <= count - COUNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit data, each stage with its own valid bit.
- Uses a valid/ready handshake, synchronous flush and an occupancy count.
- Next-generation replacement for the single enable/reset register wherever datapath pipeline stages need backpressure and squash.
- Sits between datapath stages: decode→execute, execute→memory.

Parameters:
WIDTH, 32, data bits per stage
DEPTH, 1, number of register stages (legal range 1..16)
RESET_VALUE, 0, value loaded into every stage's data register on reset/flush
COUNT_W, $clog2(DEPTH+2), width of occupancy output (covers optional skid entry)

Ports:
clk  input  1  clock, posedge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all in-flight entries
in_valid  input  1  upstream data valid
in_ready  output  1  chain can accept a beat this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  last stage data
count  output  COUNT_W  number of valid entries held

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset (sampled at posedge):
  - all valid bits 0, all data registers = RESET_VALUE;
  - out_valid=0, out_data=RESET_VALUE, count=0;
  - in_ready follows the combinational rule below (1 after reset, base build).
- Transfer rules:
  - A transfer occurs on a cycle with valid&ready at an interface.
  - Stage i (0..DEPTH-1) loads when stage_ready[i] = !valid[i] | stage_ready[i+1], with stage_ready[DEPTH] = out_ready.
  - in_ready = stage_ready[0] (combinational through the chain in the base build).
  - Stage i takes the data and valid of stage i-1 (stage 0 takes in_data/in_valid) when stage_ready[i]=1; otherwise it holds.
  - A stage whose contents are consumed and that receives no new valid becomes invalid; its data register is unchanged (no power toggling).
- Latency: a beat accepted at the edge ending cycle t is visible at out_valid/out_data in cycle t+DEPTH with no backpressure.
- Throughput: 1 beat/cycle with out_ready held 1. No bubbles are inserted; bubbles are collapsed when downstream stalls.
- Stability: with out_valid=1 and out_ready=0, out_data and out_valid hold stable until the transfer (AXI-style rule). Upstream must likewise hold in_data while in_valid=1 and in_ready=0; the bench checks this as an assertion.
- Flush:
  - At the next edge all valid bits clear and data registers load RESET_VALUE.
  - A beat presented with in_valid on the flush cycle is dropped even if in_ready=1.
  - An out transfer on the flush cycle still completes (downstream already sampled it).
- Priority: reset > flush > normal transfer.
- count: registered. Increments on an input transfer, decrements on an output transfer, unchanged on both/neither. 0 after flush/reset. Never exceeds DEPTH (DEPTH+1 with the optional feature).
- Full: all stages valid and out_ready=0 → in_ready=0.
- Empty: count=0 → out_valid=0.
- Full with out_ready=1: simultaneous in and out transfer allowed; count is unchanged.
- DEPTH=1 degenerates to a single handshaked register.

Optional Feature:
PIPE_REG_CHAIN_SKID_EN
- Defined:
  - Adds a one-entry skid buffer in front of stage 0. in_ready becomes a flop output: in_ready = !skid_valid, which breaks the combinational ready path to upstream.
  - A beat accepted while stage 0 cannot load goes into the skid buffer.
  - The skid buffer drains into stage 0 with priority over in_data.
  - Capacity is DEPTH+1; latency is unchanged when the skid is empty.
  - flush/reset also clear the skid buffer.
  - in_ready=1 from the cycle after reset.
- Undefined: no skid storage; in_ready is combinational as above; capacity is DEPTH.

Decomposition:
- Shared package pipe_pkg holds:
  - the handshake struct type (valid, data) parametrised via typedef in the user module;
  - localparam MAX_DEPTH=16;
  - the count-width function clog2_plus2.
- One natural sub-module, pipe_reg_stage: a single valid+data stage with ready-in/ready-out, reset/flush, RESET_VALUE. The chain is a generate loop of DEPTH instances plus count logic and the optional skid.

Test Plan:
1. DEPTH=3, out_ready=1, stream 0x1,0x2,0x3,0x4 on consecutive cycles → out_data 0x1..0x4 on consecutive cycles, first at accept+3; count peaks at 3.
2. DEPTH=3, fill with 0xA,0xB,0xC, out_ready=0 → count=3, in_ready=0, out_data=0xA held; raise out_ready one cycle → 0xA drains, in_ready=1 same cycle, count stays 3 if 0xD is accepted simultaneously.
3. DEPTH=4, stream 4 beats with out_ready toggled 1,0,1,0 → no beat lost or duplicated, order preserved, out_data stable while stalled.
4. Flush with 2 entries held and in_valid=1 carrying 0x55 → next cycle count=0, out_valid=0, 0x55 never appears at output.
5. Reset asserted mid-stream with DEPTH=2 and RESET_VALUE=0xDEAD → next cycle out_valid=0, out_data=0xDEAD, count=0; streaming resumes correctly on deassert.
6. With PIPE_REG_CHAIN_SKID_EN, DEPTH=2: fill 3 beats with out_ready=0 → in_ready=0 only after the 3rd beat, count=3; release → beats drain in order.
